// File: rtl/riscv_pkg.sv
// Shared types for the multicycle RISC-V controller: state encoding, opcodes,
// ALU decoder codes, immediate formats and the per-state datapath control word.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       pcupdate;
    logic       branch;
    logic       regwrite;
    logic       memwrite;
    logic       adrsrc;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore control word for a state; FETCH's mem_ready-qualified strobes are added by the top.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.resultsrc = 2'b10;
        c.alusrcb   = 2'b10;
        c.aluop     = ALUOP_ADD;
      end
      S_DECODE: begin
        c.alusrca = 2'b01;
        c.alusrcb = 2'b01;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = ALUOP_ADD;
      end
      S_MEMREAD:  c.adrsrc = 1'b1;
      S_MEMWB: begin
        c.resultsrc = 2'b01;
        c.regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adrsrc   = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXECUTER: begin
        c.alusrca = 2'b10;
        c.aluop   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB:    c.regwrite = 1'b1;
      S_JAL: begin
        c.alusrca  = 2'b01;
        c.alusrcb  = 2'b10;
        c.aluop    = ALUOP_ADD;
        c.pcupdate = 1'b1;
      end
      S_BEQ: begin
        c.alusrca = 2'b10;
        c.aluop   = ALUOP_SUB;
        c.branch  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Immediate-format decode from the opcode; purely combinational, valid in every state.
module instr_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_LOAD, OP_ITYPE: imm_src = IMM_I;
      OP_STORE:          imm_src = IMM_S;
      OP_BEQ:            imm_src = IMM_B;
      OP_JAL:            imm_src = IMM_J;
      default:           imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM with retire pulse and retired-instruction counter.
// Define MULTICYCLE_CONTROLLER_TRAP_EN to trap on illegal opcodes; otherwise they execute as NOPs.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic        mem_ready,
  output logic        PCUpdate,
  output logic        Branch,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  ImmSrc,
  output logic [3:0]  state,
  output logic        retire,
  output logic [31:0] instret,
  output logic        illegal_op
);

  state_t      r_state;
  ctrl_t       r_ctrl;
  logic        r_retire;
  logic [31:0] r_instret;
  state_t      w_next;
  logic        w_retire;
  logic        w_fetch;

  instr_decoder u_instr_decoder (
    .op      (op),
    .imm_src (ImmSrc)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECUTER;
          OP_ITYPE:          w_next = S_EXECUTEI;
          OP_JAL:            w_next = S_JAL;
          OP_BEQ:            w_next = S_BEQ;
`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
          default:           w_next = S_TRAP;
`else
          default:           w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   w_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: w_next = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_BEQ:      w_next = S_FETCH;
`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
      S_TRAP:     w_next = S_TRAP;
`else
      S_TRAP:     w_next = S_FETCH;
`endif
      default:    w_next = S_FETCH;
    endcase
  end

  // Illegal-opcode NOPs leave DECODE straight to FETCH and are deliberately absent here.
  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BEQ) ||
                    ((r_state == S_MEMWRITE) && mem_ready);

`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
  logic r_illegal;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_ctrl    <= state_ctrl(S_FETCH);
      r_retire  <= 1'b0;
      r_instret <= '0;
`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
      r_illegal <= 1'b0;
`endif
    end else begin
      r_state  <= w_next;
      r_ctrl   <= state_ctrl(w_next);
      r_retire <= w_retire;
      if (w_retire) r_instret <= r_instret + 32'd1;
`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
      r_illegal <= (w_next == S_TRAP);
`endif
    end
  end

`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
  assign illegal_op = r_illegal;
`else
  assign illegal_op = 1'b0;
`endif

  assign w_fetch   = (r_state == S_FETCH);
  assign PCUpdate  = r_ctrl.pcupdate | (w_fetch & mem_ready);
  assign IRWrite   = w_fetch & mem_ready;
  assign Branch    = r_ctrl.branch;
  assign RegWrite  = r_ctrl.regwrite;
  assign MemWrite  = r_ctrl.memwrite;
  assign AdrSrc    = r_ctrl.adrsrc;
  assign ResultSrc = r_ctrl.resultsrc;
  assign ALUSrcA   = r_ctrl.alusrca;
  assign ALUSrcB   = r_ctrl.alusrcb;
  assign ALUOp     = r_ctrl.aluop;
  assign state     = r_state;
  assign retire    = r_retire;
  assign instret   = r_instret;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expectations queued by the driver,
// popped and compared by an independent monitor.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  op;
  logic        mem_ready;
  logic        PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [3:0]  state;
  logic        retire;
  logic [31:0] instret;
  logic        illegal_op;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .state(state),
    .retire(retire), .instret(instret), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] ctl;
    logic [1:0]  imm;
    logic        ret;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic [31:0] m_cnt;
  bit          m_ret_next;

  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Control word table: {PCUpdate,Branch,RegWrite,MemWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,illegal_op}
  function automatic logic [14:0] exp_ctl(input int st, input bit mr);
    logic pcu, br, rw, mw, irw, adr, ill;
    logic [1:0] rs, a, b, alu;
    {pcu, br, rw, mw, irw, adr, ill} = '0;
    {rs, a, b, alu} = '0;
    case (st)
      0:  begin pcu = mr; irw = mr; rs = 2'b10; b = 2'b10; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  adr = 1'b1;
      4:  begin rs = 2'b01; rw = 1'b1; end
      5:  begin adr = 1'b1; mw = 1'b1; end
      6:  begin a = 2'b10; alu = 2'b10; end
      7:  rw = 1'b1;
      8:  begin a = 2'b10; b = 2'b01; alu = 2'b10; end
      9:  begin a = 2'b01; b = 2'b10; pcu = 1'b1; end
      10: begin a = 2'b10; alu = 2'b01; br = 1'b1; end
      11: ill = 1'b1;
      default: ;
    endcase
    return {pcu, br, rw, mw, irw, adr, rs, a, b, alu, ill};
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    if (o == ST) return 2'b01;
    if (o == BQ) return 2'b10;
    if (o == JL) return 2'b11;
    return 2'b00;
  endfunction

  // One cycle of stimulus plus the response expected while that cycle is visible.
  task automatic step(input int st, input bit mr, input logic [6:0] o);
    exp_t e;
    @(negedge clk);
    op = o;
    mem_ready = mr;
    if (m_ret_next) m_cnt = m_cnt + 32'd1;
    e.st  = st[3:0];
    e.ctl = exp_ctl(st, mr);
    e.imm = exp_imm(o);
    e.ret = m_ret_next;
    e.cnt = m_cnt;
    m_ret_next = 1'b0;
    exp_q.push_back(e);
  endtask

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Walk an instruction's path as the opcode table dictates; fw/mw are stall cycles.
  task automatic run_instr(input logic [6:0] o, input int fw, input int mw);
    for (int i = 0; i < fw; i++) step(0, 1'b0, o);
    step(0, 1'b1, o);
    step(1, rnd(), o);
    case (o)
      LD: begin
        step(2, rnd(), o);
        for (int i = 0; i < mw; i++) step(3, 1'b0, o);
        step(3, 1'b1, o);
        step(4, rnd(), o);
        m_ret_next = 1'b1;
      end
      ST: begin
        step(2, rnd(), o);
        for (int i = 0; i < mw; i++) step(5, 1'b0, o);
        step(5, 1'b1, o);
        m_ret_next = 1'b1;
      end
      RT: begin step(6, rnd(), o); step(7, rnd(), o); m_ret_next = 1'b1; end
      IT: begin step(8, rnd(), o); step(7, rnd(), o); m_ret_next = 1'b1; end
      JL: begin step(9, rnd(), o); step(7, rnd(), o); m_ret_next = 1'b1; end
      BQ: begin step(10, rnd(), o); m_ret_next = 1'b1; end
      default: begin
`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
        for (int i = 0; i < 3; i++) step(11, rnd(), o);
`endif
      end
    endcase
  endtask

  task automatic drain();
    @(negedge clk);
    #2;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", 64'(state), 64'(e.st));
        chk("ctrl", 64'({PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc,
                         ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal_op}), 64'(e.ctl));
        chk("immsrc", 64'(ImmSrc), 64'(e.imm));
        chk("retire_instret", 64'({retire, instret}), 64'({e.ret, e.cnt}));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [6:0] ops [8];
    int n_ops;
    ops = '{RT, LD, ST, BQ, JL, IT, BAD, 7'b0000000};
`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
    n_ops = 6;
`else
    n_ops = 8;
`endif
    m_cnt = '0;
    m_ret_next = 1'b0;
    rst_n = 1'b0;
    op = '0;
    mem_ready = 1'b0;
    #1;
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_instret", 64'(instret), 64'd0);
    chk("reset_retire", 64'(retire), 64'd0);
    chk("reset_illegal", 64'(illegal_op), 64'd0);
    #2 rst_n = 1'b1;

    run_instr(RT, 0, 0);
    run_instr(LD, 1, 2);
    run_instr(ST, 0, 2);
    run_instr(BQ, 0, 0);
    run_instr(JL, 2, 0);
    run_instr(IT, 0, 1);
`ifndef MULTICYCLE_CONTROLLER_TRAP_EN
    run_instr(BAD, 0, 0);
`endif
    for (int k = 0; k < 40; k++)
      run_instr(ops[$urandom_range(0, n_ops - 1)], $urandom_range(0, 2), $urandom_range(0, 3));

    // Counter wrap: preload while idling in FETCH, then retire one instruction.
    step(0, 1'b0, RT);
    drain();
    force dut.r_instret = 32'hFFFF_FFFF;
    #1 release dut.r_instret;
    m_cnt = 32'hFFFF_FFFF;
    run_instr(RT, 0, 0);
    step(0, 1'b0, RT);
    drain();
    chk("instret_wrapped", 64'(instret), 64'd0);

    // Asynchronous reset in the middle of a stalled store.
    step(0, 1'b1, ST);
    step(1, 1'b0, ST);
    step(2, 1'b0, ST);
    step(5, 1'b0, ST);
    step(5, 1'b0, ST);
    drain();
    chk("pre_reset_state", 64'(state), 64'd5);
    chk("pre_reset_memwrite", 64'(MemWrite), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_state", 64'(state), 64'd0);
    chk("async_reset_memwrite", 64'(MemWrite), 64'd0);
    chk("async_reset_instret", 64'(instret), 64'd0);
    #1 rst_n = 1'b1;
    m_cnt = '0;
    m_ret_next = 1'b0;

`ifdef MULTICYCLE_CONTROLLER_TRAP_EN
    run_instr(BAD, 0, 0);
    drain();
    chk("trap_held_state", 64'(state), 64'd11);
    chk("trap_held_illegal", 64'(illegal_op), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("trap_reset_illegal", 64'(illegal_op), 64'd0);
    chk("trap_reset_state", 64'(state), 64'd0);
    #1 rst_n = 1'b1;
    m_cnt = '0;
    m_ret_next = 1'b0;
`endif

    run_instr(RT, 1, 0);
    step(0, 1'b0, RT);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
